nav_motor_controller: RTL and testbench
=======================================

// Module: nav_motor_controller
// PURPOSE
//  Multi-sensor, parametrised successor of the single-sensor obstacle/stop controller.
//  Takes front/left/right ultrasonic distances and outputs a one-hot drive direction.
//  An internal timed FSM stops, picks the clearer side and turns, backs up when both
//  sides are blocked, and latches a stuck fault after repeated failed escapes.
//  Sits between the sensor front-end and the motor driver.
// PARAMETERS
//  DIST_W       16        distance sample width (sensor units)
//  STOP_DIST    10        front distance < STOP_DIST => front blocked
//  CLEAR_DIST   20        side distance >= CLEAR_DIST => side usable; also hysteresis release
//  HOLD_COUNTS  6250000   STOP_HOLD dwell in clk cycles (50 ms @ 125 MHz)
//  TURN_COUNTS  25000000  TURN_L/TURN_R dwell in clk cycles (200 ms)
//  BACK_COUNTS  12500000  BACK dwell in clk cycles (100 ms)
//  MAX_RETRIES  3         failed escapes before FAULT (1..15)
// PORTS
//  clk         in   1        system clock
//  reset       in   1        synchronous, active-high reset
//  enable      in   1        1 = autonomous drive allowed
//  dist_valid  in   1        1-cycle strobe: dist_* are valid this cycle
//  dist_front  in   DIST_W   front distance
//  dist_left   in   DIST_W   left distance
//  dist_right  in   DIST_W   right distance
//  direction   out  5        one-hot: 00001 FWD, 00010 BACK, 00100 LEFT, 01000 RIGHT, 10000 STOP
//  stuck       out  1        level, 1 while in FAULT
//  state_dbg   out  3        current state encoding (below)
// BEHAVIOUR
//  - Reset: state IDLE, direction=10000, stuck=0, state_dbg=0, retry=0, timer=0, sample regs=0.
//  - Sample regs load dist_* on the edge where dist_valid=1; all decisions use sample regs.
//  - front_blk = (front_s < STOP_DIST); equal to STOP_DIST is clear. 0 (no echo) is blocked.
//  - States/dbg: IDLE=0 FWD=1 STOP_HOLD=2 TURN_L=3 TURN_R=4 BACK=5 FAULT=6.
//  - direction, stuck, state_dbg are registered from the next state and change on the
//    same edge as state. Blocked sample captured at edge k in FWD -> STOP at edge k+1.
//  - Timer: one down-counter, loaded with (state dwell - 1) on entry to a timed state;
//    expiry = count 0 while in that state. Dwell is exactly the state's COUNTS cycles.
//  - IDLE (STOP): enable=1 -> FWD; retry cleared.
//  - FWD: front_blk -> STOP_HOLD.
//  - STOP_HOLD (STOP): on expiry, choose side with left_s/right_s >= CLEAR_DIST;
//    both usable -> larger wins, tie -> LEFT; none usable -> BACK.
//  - TURN_x: on expiry, front clear -> FWD, retry=0; else retry+1 -> STOP_HOLD.
//  - BACK: on expiry, retry+1 -> STOP_HOLD.
//  - Any increment reaching MAX_RETRIES goes to FAULT instead of STOP_HOLD.
//  - FAULT: direction=STOP, stuck=1; exits only via enable=0 -> IDLE.
//  - enable=0 in any state -> IDLE on next edge; it wins over simultaneous expiry or
//    dist_valid. dist_valid during a dwell updates samples but does not abort the dwell.
//  - reset mid-dwell: immediate return to reset values; no partial dwell kept.
// CONFIGURATION
//  OBSTACLE_HYST_EN defined: front_blk is a registered flag. It sets when front_s
//    < STOP_DIST, clears only when front_s >= CLEAR_DIST, holds in between. The flag
//    resets to 1, so the first FWD needs a clear sample >= CLEAR_DIST.
//  Not defined: front_blk is combinational (front_s < STOP_DIST), no memory.
// TESTING (HOLD=4, TURN=8, BACK=6, STOP_DIST=10, CLEAR_DIST=20, MAX_RETRIES=2)
//  1 reset, enable=1, front=50 strobed -> FWD 00001 one edge after enable; stuck=0.
//  2 FWD, strobe front=9 left=30 right=40 -> STOP next edge, 4 cycles later RIGHT 01000;
//    after 8 cycles strobe front=50 -> FWD; left=right=40 tie -> LEFT 00100.
//  3 front=9 left=5 right=5 held -> STOP(4) BACK 00010(6) STOP(4) BACK(6) -> FAULT,
//    stuck=1 and STOP. enable=0 -> IDLE, stuck=0 next edge.
//  4 front=10 exactly in FWD -> stays FWD. With OBSTACLE_HYST_EN: 9 then 15 stays
//    blocked, 20 releases.
//  5 enable=0 on the same edge as TURN_R expiry -> IDLE/STOP next edge, retry=0.
//  6 reset=1 mid-BACK dwell -> next edge all outputs at reset values. Re-enable gives
//    a full dwell count.

Source files
------------

// File: rtl/nav_motor_controller.sv
// nav_motor_controller
//   Multi-sensor obstacle-avoidance controller. Registers front/left/right
//   ultrasonic distances, runs a timed FSM (stop, pick side and turn, or back
//   up), and latches a stuck fault after repeated failed escapes.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   enable              1 = autonomous drive allowed; 0 forces IDLE
//   dist_valid          strobe: dist_* are captured on this edge
//   dist_front/left/right  distance samples (DIST_W bits)
//   direction           one-hot: FWD 00001, BACK 00010, LEFT 00100, RIGHT 01000, STOP 10000
//   stuck               1 while in FAULT
//   state_dbg           state encoding (IDLE=0 FWD=1 STOP_HOLD=2 TURN_L=3 TURN_R=4 BACK=5 FAULT=6)
//
// Configuration
//   OBSTACLE_HYST_EN    when defined, front blocking uses a hysteresis flag
//                       (sets below STOP_DIST, clears at/above CLEAR_DIST,
//                       resets to blocked).
module nav_motor_controller #(
  parameter int unsigned DIST_W      = 16,
  parameter int unsigned STOP_DIST   = 10,
  parameter int unsigned CLEAR_DIST  = 20,
  parameter int unsigned HOLD_COUNTS = 6250000,
  parameter int unsigned TURN_COUNTS = 25000000,
  parameter int unsigned BACK_COUNTS = 12500000,
  parameter int unsigned MAX_RETRIES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              dist_valid,
  input  logic [DIST_W-1:0] dist_front,
  input  logic [DIST_W-1:0] dist_left,
  input  logic [DIST_W-1:0] dist_right,
  output logic [4:0]        direction,
  output logic              stuck,
  output logic [2:0]        state_dbg
);

  localparam int unsigned TMR_W   = 32;
  localparam int unsigned RETRY_W = 4;

  localparam logic [4:0] DIR_FWD   = 5'b00001;
  localparam logic [4:0] DIR_BACK  = 5'b00010;
  localparam logic [4:0] DIR_LEFT  = 5'b00100;
  localparam logic [4:0] DIR_RIGHT = 5'b01000;
  localparam logic [4:0] DIR_STOP  = 5'b10000;

  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_COUNTS - 32'd1);
  localparam logic [TMR_W-1:0] TURN_LOAD = TMR_W'(TURN_COUNTS - 32'd1);
  localparam logic [TMR_W-1:0] BACK_LOAD = TMR_W'(BACK_COUNTS - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FWD    = 3'd1,
    S_HOLD   = 3'd2,
    S_TURN_L = 3'd3,
    S_TURN_R = 3'd4,
    S_BACK   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  state_t              state;
  logic [TMR_W-1:0]    timer;
  logic [RETRY_W-1:0]  retry;
  logic [RETRY_W-1:0]  retry_inc;
  logic [DIST_W-1:0]   front_s;
  logic [DIST_W-1:0]   left_s;
  logic [DIST_W-1:0]   right_s;
  logic                front_blk;
  logic                left_ok;
  logic                right_ok;
  logic                timer_done;

  assign left_ok    = (left_s  >= DIST_W'(CLEAR_DIST));
  assign right_ok   = (right_s >= DIST_W'(CLEAR_DIST));
  assign retry_inc  = retry + RETRY_W'(1);
  assign timer_done = (timer == '0);

`ifdef OBSTACLE_HYST_EN
  // Hysteresis flag tracks the sample registers: updated on the same strobe.
  logic blk_flag;
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_flag <= 1'b1;
    end else if (dist_valid) begin
      if (dist_front < DIST_W'(STOP_DIST))
        blk_flag <= 1'b1;
      else if (dist_front >= DIST_W'(CLEAR_DIST))
        blk_flag <= 1'b0;
    end
  end
  assign front_blk = blk_flag;
`else
  assign front_blk = (front_s < DIST_W'(STOP_DIST));
`endif

  function automatic logic [4:0] dir_of(input state_t s);
    case (s)
      S_FWD:    dir_of = DIR_FWD;
      S_BACK:   dir_of = DIR_BACK;
      S_TURN_L: dir_of = DIR_LEFT;
      S_TURN_R: dir_of = DIR_RIGHT;
      default:  dir_of = DIR_STOP;
    endcase
  endfunction

  // Move to a state and register its outputs on the same edge.
  task automatic go(input state_t s);
    state     <= s;
    state_dbg <= s;
    stuck     <= (s == S_FAULT);
    direction <= dir_of(s);
  endtask

  // Escape attempt failed: count it, fault once the limit is reached.
  task automatic escape_failed();
    retry <= retry_inc;
    if (retry_inc >= RETRY_W'(MAX_RETRIES)) begin
      go(S_FAULT);
    end else begin
      go(S_HOLD);
      timer <= HOLD_LOAD;
    end
  endtask

  always_ff @(posedge clk) begin
    if (reset) begin
      go(S_IDLE);
      timer   <= '0;
      retry   <= '0;
      front_s <= '0;
      left_s  <= '0;
      right_s <= '0;
    end else begin
      if (dist_valid) begin
        front_s <= dist_front;
        left_s  <= dist_left;
        right_s <= dist_right;
      end

      // Disable wins over any expiry in progress.
      if (!enable) begin
        go(S_IDLE);
        retry <= '0;
        timer <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            go(S_FWD);
            retry <= '0;
          end
          S_FWD: begin
            if (front_blk) begin
              go(S_HOLD);
              timer <= HOLD_LOAD;
            end
          end
          S_HOLD: begin
            if (timer_done) begin
              // Larger clear side wins, ties go left.
              if (left_ok && (!right_ok || left_s >= right_s)) begin
                go(S_TURN_L);
                timer <= TURN_LOAD;
              end else if (right_ok) begin
                go(S_TURN_R);
                timer <= TURN_LOAD;
              end else begin
                go(S_BACK);
                timer <= BACK_LOAD;
              end
            end else begin
              timer <= timer - TMR_W'(1);
            end
          end
          S_TURN_L, S_TURN_R: begin
            if (timer_done) begin
              if (!front_blk) begin
                go(S_FWD);
                retry <= '0;
              end else begin
                escape_failed();
              end
            end else begin
              timer <= timer - TMR_W'(1);
            end
          end
          S_BACK: begin
            if (timer_done)
              escape_failed();
            else
              timer <= timer - TMR_W'(1);
          end
          S_FAULT: begin
            go(S_FAULT);
          end
          default: begin
            go(S_IDLE);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nav_motor_controller.sv
// Bench for nav_motor_controller: directed scenario tables checked against
// constants, then randomized stimulus checked against a behavioural model.
module tb_nav_motor_controller;

  localparam int STOP = 10;
  localparam int CLR  = 20;
  localparam int HOLD = 4;
  localparam int TURN = 8;
  localparam int BACK = 6;
  localparam int MAXR = 2;

  localparam logic [8:0] E_IDLE  = {5'b10000, 1'b0, 3'd0};
  localparam logic [8:0] E_FWD   = {5'b00001, 1'b0, 3'd1};
  localparam logic [8:0] E_HOLD  = {5'b10000, 1'b0, 3'd2};
  localparam logic [8:0] E_TL    = {5'b00100, 1'b0, 3'd3};
  localparam logic [8:0] E_TR    = {5'b01000, 1'b0, 3'd4};
  localparam logic [8:0] E_BACK  = {5'b00010, 1'b0, 3'd5};
  localparam logic [8:0] E_FAULT = {5'b10000, 1'b1, 3'd6};

  logic        clk;
  logic        reset;
  logic        enable;
  logic        dist_valid;
  logic [15:0] dist_front;
  logic [15:0] dist_left;
  logic [15:0] dist_right;
  logic [4:0]  direction;
  logic        stuck;
  logic [2:0]  state_dbg;
  logic [8:0]  obs;

  assign obs = {direction, stuck, state_dbg};

  nav_motor_controller #(
    .DIST_W(16), .STOP_DIST(STOP), .CLEAR_DIST(CLR),
    .HOLD_COUNTS(HOLD), .TURN_COUNTS(TURN), .BACK_COUNTS(BACK),
    .MAX_RETRIES(MAXR)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .dist_valid(dist_valid),
    .dist_front(dist_front), .dist_left(dist_left), .dist_right(dist_right),
    .direction(direction), .stuck(stuck), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Scenario row: n cycles with the same inputs; the strobe only on the first.
  typedef struct {
    int         n;
    bit         r;
    bit         en;
    bit         dv;
    int         f;
    int         l;
    int         rt;
    logic [8:0] want;
  } row_t;

  function automatic row_t mk(int n, bit r, bit en, bit dv, int f, int l, int rt,
                              logic [8:0] want);
    row_t x;
    x.n = n; x.r = r; x.en = en; x.dv = dv; x.f = f; x.l = l; x.rt = rt; x.want = want;
    return x;
  endfunction

  // Behavioural model: state number, cycles spent in current state, retries.
  int m_state, m_el, m_retry, m_f, m_l, m_r;
  bit m_flag;

  task automatic m_enter(input int s);
    m_state = s;
    m_el    = 1;
  endtask

  task automatic m_fail();
    m_retry++;
    if (m_retry >= MAXR) m_state = 6;
    else m_enter(2);
  endtask

  task automatic model_edge(input bit r, input bit en, input bit dv,
                            input int f, input int l, input int rt);
    bit blk;
    bit lo, ro;
`ifdef OBSTACLE_HYST_EN
    blk = m_flag;
`else
    blk = (m_f < STOP);
`endif
    lo = (m_l >= CLR);
    ro = (m_r >= CLR);
    if (r) begin
      m_state = 0; m_el = 0; m_retry = 0;
      m_f = 0; m_l = 0; m_r = 0; m_flag = 1'b1;
      return;
    end
    if (!en) begin
      m_state = 0;
      m_retry = 0;
    end else begin
      case (m_state)
        0: begin m_state = 1; m_retry = 0; end
        1: if (blk) m_enter(2);
        2: if (m_el == HOLD) begin
             if (lo && ro) m_enter((m_l >= m_r) ? 3 : 4);
             else if (lo) m_enter(3);
             else if (ro) m_enter(4);
             else m_enter(5);
           end else m_el++;
        3, 4: if (m_el == TURN) begin
                if (!blk) begin m_state = 1; m_retry = 0; end
                else m_fail();
              end else m_el++;
        5: if (m_el == BACK) m_fail(); else m_el++;
        default: ;
      endcase
    end
    if (dv) begin
      m_f = f; m_l = l; m_r = rt;
      if (f < STOP) m_flag = 1'b1;
      else if (f >= CLR) m_flag = 1'b0;
    end
  endtask

  function automatic logic [8:0] model_obs();
    logic [4:0] d;
    case (m_state)
      1: d = 5'b00001;
      3: d = 5'b00100;
      4: d = 5'b01000;
      5: d = 5'b00010;
      default: d = 5'b10000;
    endcase
    return {d, (m_state == 6), 3'(m_state)};
  endfunction

  // Drive inputs, take one clock edge, advance the model, settle past the edge.
  task automatic tick(input bit r, input bit en, input bit dv,
                      input int f, input int l, input int rt);
    reset      = r;
    enable     = en;
    dist_valid = dv;
    dist_front = 16'(f);
    dist_left  = 16'(l);
    dist_right = 16'(rt);
    @(posedge clk);
    model_edge(r, en, dv, f, l, rt);
    #1;
  endtask

  task automatic test_reset();
    row_t t[$];
    t.push_back(mk(2, 1, 0, 0, 0, 0, 0, E_IDLE));
    t.push_back(mk(1, 0, 0, 1, 50, 30, 30, E_IDLE));
    t.push_back(mk(1, 0, 1, 0, 0, 0, 0, E_FWD));
    t.push_back(mk(2, 0, 1, 0, 0, 0, 0, E_FWD));
    foreach (t[i]) for (int k = 0; k < t[i].n; k++) begin
      tick(t[i].r, t[i].en, (k == 0) ? t[i].dv : 1'b0, t[i].f, t[i].l, t[i].rt);
      vectors++;
      if (obs !== t[i].want) begin
        miscompares++;
        $display("FAIL reset row %0d cyc %0d: dir/stuck/dbg got %b want %b", i, k, obs, t[i].want);
      end
    end
  endtask

  task automatic test_turn();
    row_t t[$];
    t.push_back(mk(1, 0, 1, 1, 9, 30, 40, E_FWD));
    t.push_back(mk(4, 0, 1, 0, 0, 0, 0, E_HOLD));
    t.push_back(mk(1, 0, 1, 0, 0, 0, 0, E_TR));
    t.push_back(mk(7, 0, 1, 1, 50, 40, 40, E_TR));
    t.push_back(mk(1, 0, 1, 0, 0, 0, 0, E_FWD));
    t.push_back(mk(1, 0, 1, 1, 9, 40, 40, E_FWD));
    t.push_back(mk(4, 0, 1, 0, 0, 0, 0, E_HOLD));
    t.push_back(mk(1, 0, 1, 0, 0, 0, 0, E_TL));
    t.push_back(mk(7, 0, 1, 1, 50, 40, 40, E_TL));
    t.push_back(mk(1, 0, 1, 0, 0, 0, 0, E_FWD));
    foreach (t[i]) for (int k = 0; k < t[i].n; k++) begin
      tick(t[i].r, t[i].en, (k == 0) ? t[i].dv : 1'b0, t[i].f, t[i].l, t[i].rt);
      vectors++;
      if (obs !== t[i].want) begin
        miscompares++;
        $display("FAIL turn row %0d cyc %0d: dir/stuck/dbg got %b want %b", i, k, obs, t[i].want);
      end
    end
  endtask

  task automatic test_back_fault();
    row_t t[$];
    t.push_back(mk(1, 0, 1, 1, 9, 5, 5, E_FWD));
    t.push_back(mk(4, 0, 1, 0, 0, 0, 0, E_HOLD));
    t.push_back(mk(6, 0, 1, 0, 0, 0, 0, E_BACK));
    t.push_back(mk(4, 0, 1, 0, 0, 0, 0, E_HOLD));
    t.push_back(mk(6, 0, 1, 0, 0, 0, 0, E_BACK));
    t.push_back(mk(3, 0, 1, 0, 0, 0, 0, E_FAULT));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, E_IDLE));
    foreach (t[i]) for (int k = 0; k < t[i].n; k++) begin
      tick(t[i].r, t[i].en, (k == 0) ? t[i].dv : 1'b0, t[i].f, t[i].l, t[i].rt);
      vectors++;
      if (obs !== t[i].want) begin
        miscompares++;
        $display("FAIL back_fault row %0d cyc %0d: dir/stuck/dbg got %b want %b", i, k, obs, t[i].want);
      end
    end
  endtask

  task automatic test_front_boundary();
    row_t t[$];
`ifdef OBSTACLE_HYST_EN
    t.push_back(mk(1, 0, 0, 1, 9, 5, 5, E_IDLE));
    t.push_back(mk(1, 0, 0, 1, 15, 5, 5, E_IDLE));
    t.push_back(mk(1, 0, 1, 0, 0, 0, 0, E_FWD));
    t.push_back(mk(1, 0, 1, 0, 0, 0, 0, E_HOLD));
    t.push_back(mk(1, 0, 0, 1, 20, 5, 5, E_IDLE));
    t.push_back(mk(1, 0, 1, 0, 0, 0, 0, E_FWD));
    t.push_back(mk(3, 0, 1, 1, 15, 5, 5, E_FWD));
`else
    t.push_back(mk(1, 0, 0, 1, 10, 5, 5, E_IDLE));
    t.push_back(mk(1, 0, 1, 0, 0, 0, 0, E_FWD));
    t.push_back(mk(4, 0, 1, 0, 0, 0, 0, E_FWD));
`endif
    t.push_back(mk(1, 0, 1, 1, 0, 5, 5, E_FWD));
    t.push_back(mk(1, 0, 1, 0, 0, 0, 0, E_HOLD));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, E_IDLE));
    foreach (t[i]) for (int k = 0; k < t[i].n; k++) begin
      tick(t[i].r, t[i].en, (k == 0) ? t[i].dv : 1'b0, t[i].f, t[i].l, t[i].rt);
      vectors++;
      if (obs !== t[i].want) begin
        miscompares++;
        $display("FAIL front_boundary row %0d cyc %0d: dir/stuck/dbg got %b want %b", i, k, obs, t[i].want);
      end
    end
  endtask

  task automatic test_enable_abort();
    row_t t[$];
    t.push_back(mk(1, 0, 0, 1, 50, 5, 30, E_IDLE));
    t.push_back(mk(1, 0, 1, 0, 0, 0, 0, E_FWD));
    t.push_back(mk(1, 0, 1, 1, 9, 5, 30, E_FWD));
    t.push_back(mk(4, 0, 1, 0, 0, 0, 0, E_HOLD));
    t.push_back(mk(8, 0, 1, 0, 0, 0, 0, E_TR));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, E_IDLE));
    // Retry must be zero again: one failed escape lands in STOP_HOLD, not FAULT.
    t.push_back(mk(1, 0, 1, 1, 9, 5, 5, E_FWD));
    t.push_back(mk(4, 0, 1, 0, 0, 0, 0, E_HOLD));
    t.push_back(mk(6, 0, 1, 0, 0, 0, 0, E_BACK));
    t.push_back(mk(1, 0, 1, 0, 0, 0, 0, E_HOLD));
    foreach (t[i]) for (int k = 0; k < t[i].n; k++) begin
      tick(t[i].r, t[i].en, (k == 0) ? t[i].dv : 1'b0, t[i].f, t[i].l, t[i].rt);
      vectors++;
      if (obs !== t[i].want) begin
        miscompares++;
        $display("FAIL enable_abort row %0d cyc %0d: dir/stuck/dbg got %b want %b", i, k, obs, t[i].want);
      end
    end
  endtask

  task automatic test_reset_mid_dwell();
    row_t t[$];
    t.push_back(mk(3, 0, 1, 0, 0, 0, 0, E_HOLD));
    t.push_back(mk(3, 0, 1, 0, 0, 0, 0, E_BACK));
    t.push_back(mk(1, 1, 1, 0, 0, 0, 0, E_IDLE));
    t.push_back(mk(1, 0, 0, 1, 9, 5, 5, E_IDLE));
    t.push_back(mk(1, 0, 1, 0, 0, 0, 0, E_FWD));
    t.push_back(mk(4, 0, 1, 0, 0, 0, 0, E_HOLD));
    t.push_back(mk(6, 0, 1, 0, 0, 0, 0, E_BACK));
    t.push_back(mk(1, 0, 1, 0, 0, 0, 0, E_HOLD));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, E_IDLE));
    foreach (t[i]) for (int k = 0; k < t[i].n; k++) begin
      tick(t[i].r, t[i].en, (k == 0) ? t[i].dv : 1'b0, t[i].f, t[i].l, t[i].rt);
      vectors++;
      if (obs !== t[i].want) begin
        miscompares++;
        $display("FAIL reset_mid_dwell row %0d cyc %0d: dir/stuck/dbg got %b want %b", i, k, obs, t[i].want);
      end
    end
  endtask

  task automatic test_random();
    int pool [10] = '{0, 5, 9, 10, 15, 19, 20, 25, 40, 60};
    logic [8:0] want;
    bit r, en, dv;
    for (int c = 0; c < 4000; c++) begin
      r  = (c == 0) || ($urandom_range(0, 399) == 0);
      en = ($urandom_range(0, 79) != 0);
      dv = ($urandom_range(0, 3) == 0);
      tick(r, en, dv, pool[$urandom_range(0, 9)], pool[$urandom_range(0, 9)],
           pool[$urandom_range(0, 9)]);
      want = model_obs();
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL random cyc %0d: dir/stuck/dbg got %b want %b", c, obs, want);
      end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; dist_valid = 1'b0;
    dist_front = '0; dist_left = '0; dist_right = '0;
    m_state = 0; m_el = 0; m_retry = 0; m_f = 0; m_l = 0; m_r = 0; m_flag = 1'b1;
    test_reset();
    test_turn();
    test_back_fault();
    test_front_boundary();
    test_enable_abort();
    test_reset_mid_dwell();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
